// File: rtl/hdmi_pkg.sv
// Shared constants and types for the HDMI DDR serialiser.
// Channel map: 0 blue, 1 green, 2 red, 3 TMDS clock.
package hdmi_pkg;

  localparam int SYMBOL_WIDTH = 10;
  localparam int PIXEL_PHASES = 5;
  localparam int NUM_DATA_CH  = 3;
  localparam int NUM_CH       = 4;

  localparam int CH_BLUE  = 0;
  localparam int CH_GREEN = 1;
  localparam int CH_RED   = 2;
  localparam int CH_CLOCK = 3;

  localparam logic [SYMBOL_WIDTH-1:0] TMDS_CLOCK_PATTERN =
    10'b0000011111;

  localparam logic [2:0] LAST_PHASE = 3'(PIXEL_PHASES - 1);

  typedef enum logic {
    IDLE,
    RUN
  } ser_state_e;

  typedef logic [2:0] phase_t;

  // Rise/fall pair {sym[2k+1], sym[2k]} for phase k.
  function automatic logic [1:0] pattern_pair(
    input phase_t                  ph,
    input logic [SYMBOL_WIDTH-1:0] pat
  );
    logic [SYMBOL_WIDTH-1:0] s;
    s = pat >> (2 * ph);
    return s[1:0];
  endfunction

endpackage

// File: rtl/hdmi_ddr_serializer_lock.sv
// PLL lock synchroniser plus saturating qualification counter.
// qualified_o is high once lk has been 1 for LOCK_CYCLES cycles.
module hdmi_lock_qualifier #(
  parameter int LOCK_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic locked_i,
  output logic qualified_o,
  output logic lk_o
);

  localparam logic [15:0] LIMIT = 16'(LOCK_CYCLES);

  logic        meta_q;
  logic        lk_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!lk_q) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      lk_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= locked_i;
      lk_q   <= meta_q;
      cnt_q  <= cnt_d;
    end
  end

  assign qualified_o = lk_q && (cnt_q == LIMIT);
  assign lk_o        = lk_q;

endmodule

// File: rtl/hdmi_ddr_serializer.sv
// Five-phase TMDS serialiser feeding SB_IO DDR cells, LSB first.
// Optional HDMI_SER_INVERT_EN applies INVERT_MASK per channel.
module hdmi_ddr_serializer
  import hdmi_pkg::*;
#(
  parameter int         LOCK_CYCLES = 1024,
  parameter logic [3:0] INVERT_MASK = 4'b0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    locked,
  input  logic [SYMBOL_WIDTH-1:0] tmds_blue,
  input  logic [SYMBOL_WIDTH-1:0] tmds_green,
  input  logic [SYMBOL_WIDTH-1:0] tmds_red,
  output logic                    pixel_strobe,
  output logic                    active,
  output logic [NUM_CH-1:0]       out_rise,
  output logic [NUM_CH-1:0]       out_fall
);

`ifdef HDMI_SER_INVERT_EN
  localparam logic [NUM_CH-1:0] INV = INVERT_MASK;
`else
  localparam logic [NUM_CH-1:0] INV = INVERT_MASK & 4'b0000;
`endif

  logic qualified;
  logic lk;

  hdmi_lock_qualifier #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock (
    .clk_i      (clk),
    .rst_i      (reset),
    .locked_i   (locked),
    .qualified_o(qualified),
    .lk_o       (lk)
  );

  logic [NUM_DATA_CH-1:0][SYMBOL_WIDTH-1:0] sym;

  always_comb begin
    sym           = '0;
    sym[CH_BLUE]  = tmds_blue;
    sym[CH_GREEN] = tmds_green;
    sym[CH_RED]   = tmds_red;
  end

  ser_state_e                               state_q;
  phase_t                                   phase_q;
  phase_t                                   phase_d;
  logic                                     strobe_q;
  logic [NUM_CH-1:0]                        rise_q;
  logic [NUM_CH-1:0]                        fall_q;
  logic [NUM_DATA_CH-1:0][SYMBOL_WIDTH-1:0] sh_q;
  logic [1:0]                               clk_pair;

  assign phase_d  = (phase_q == LAST_PHASE) ? 3'd0
                                            : phase_q + 3'd1;
  assign clk_pair = pattern_pair(phase_d, TMDS_CLOCK_PATTERN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      strobe_q <= 1'b0;
      rise_q   <= '0;
      fall_q   <= '0;
      sh_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          phase_q  <= '0;
          strobe_q <= 1'b0;
          rise_q   <= '0;
          fall_q   <= '0;
          sh_q     <= '0;
          // Enter in the strobe phase so the first sample aligns.
          if (qualified) begin
            state_q  <= RUN;
            phase_q  <= LAST_PHASE;
            strobe_q <= 1'b1;
          end
        end
        RUN: begin
          if (!lk) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            strobe_q <= 1'b0;
            rise_q   <= '0;
            fall_q   <= '0;
            sh_q     <= '0;
          end else begin
            phase_q          <= phase_d;
            strobe_q         <= (phase_d == LAST_PHASE);
            rise_q[CH_CLOCK] <= clk_pair[0];
            fall_q[CH_CLOCK] <= clk_pair[1];
            for (int ch = 0; ch < NUM_DATA_CH; ch++) begin
              if (phase_q == LAST_PHASE) begin
                rise_q[ch] <= sym[ch][0];
                fall_q[ch] <= sym[ch][1];
                sh_q[ch]   <= sym[ch] >> 2;
              end else begin
                rise_q[ch] <= sh_q[ch][0];
                fall_q[ch] <= sh_q[ch][1];
                sh_q[ch]   <= sh_q[ch] >> 2;
              end
            end
          end
        end
      endcase
    end
  end

  assign pixel_strobe = strobe_q;
  assign active       = (state_q == RUN);
  assign out_rise     = rise_q ^ INV;
  assign out_fall     = fall_q ^ INV;

endmodule

// File: tb/tb_hdmi_ddr_serializer.sv
// Directed bench for hdmi_ddr_serializer with LOCK_CYCLES=1024.
// Expected output words are XORed with the idle value of the build.
module tb_hdmi_ddr_serializer;

  localparam int         LC   = 1024;
  localparam logic [3:0] MASK = 4'b0101;
`ifdef HDMI_SER_INVERT_EN
  localparam logic [3:0] IV = MASK;
`else
  localparam logic [3:0] IV = 4'b0000;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       locked;
  logic [9:0] tb_blue;
  logic [9:0] tb_green;
  logic [9:0] tb_red;
  logic       pixel_strobe;
  logic       active;
  logic [3:0] out_rise;
  logic [3:0] out_fall;

  int checks   = 0;
  int failures = 0;

  hdmi_ddr_serializer #(
    .LOCK_CYCLES(LC),
    .INVERT_MASK(MASK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .locked      (locked),
    .tmds_blue   (tb_blue),
    .tmds_green  (tb_green),
    .tmds_red    (tb_red),
    .pixel_strobe(pixel_strobe),
    .active      (active),
    .out_rise    (out_rise),
    .out_fall    (out_fall)
  );

  always #4 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(
    input string      tag,
    input logic [3:0] r,
    input logic [3:0] f
  );
    chk({tag, "_rise"}, out_rise, r ^ IV);
    chk({tag, "_fall"}, out_fall, f ^ IV);
  endtask

  task automatic stepn(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    locked   = 1'b1;
    tb_blue  = '0;
    tb_green = '0;
    tb_red   = '0;
    stepn(2);
    chk("rst_active", {3'b0, active}, 4'd0);
    chk("rst_strobe", {3'b0, pixel_strobe}, 4'd0);
    chk_out("rst", 4'b0000, 4'b0000);

    reset = 1'b0;
    stepn(LC + 2);
    chk("pre_active", {3'b0, active}, 4'd0);
    chk_out("pre", 4'b0000, 4'b0000);
    stepn(1);
    chk("first_active", {3'b0, active}, 4'd1);
    chk("first_strobe", {3'b0, pixel_strobe}, 4'd1);
    chk_out("first", 4'b0000, 4'b0000);

    tb_blue  = 10'b1101001110;
    tb_green = 10'h3FF;
    tb_red   = 10'h000;
    stepn(1);
    chk_out("s1p0", 4'b1010, 4'b1011);
    chk("s1p0_strobe", {3'b0, pixel_strobe}, 4'd0);
    tb_blue  = 10'h000;
    tb_green = 10'h000;
    tb_red   = 10'h3FF;
    stepn(1);
    chk_out("s1p1", 4'b1011, 4'b1011);
    chk("s1p1_strobe", {3'b0, pixel_strobe}, 4'd0);
    stepn(1);
    chk_out("s1p2", 4'b1010, 4'b0010);
    chk("s1p2_strobe", {3'b0, pixel_strobe}, 4'd0);
    stepn(1);
    chk_out("s1p3", 4'b0011, 4'b0010);
    chk("s1p3_strobe", {3'b0, pixel_strobe}, 4'd0);
    stepn(1);
    chk_out("s1p4", 4'b0011, 4'b0011);
    chk("s1p4_strobe", {3'b0, pixel_strobe}, 4'd1);

    stepn(1);
    chk_out("s2p0", 4'b1100, 4'b1100);
    chk("s2p0_strobe", {3'b0, pixel_strobe}, 4'd0);
    stepn(1);
    chk_out("s2p1", 4'b1100, 4'b1100);
    stepn(1);
    chk_out("s2p2", 4'b1100, 4'b0100);
    stepn(1);
    chk_out("s2p3", 4'b0100, 4'b0100);
    stepn(1);
    chk_out("s2p4", 4'b0100, 4'b0100);
    chk("s2p4_strobe", {3'b0, pixel_strobe}, 4'd1);

    stepn(1);
    chk_out("s3p0", 4'b1100, 4'b1100);
    stepn(1);
    chk_out("s3p1", 4'b1100, 4'b1100);
    stepn(1);
    chk_out("s3p2", 4'b1100, 4'b0100);
    locked = 1'b0;
    stepn(1);
    chk("drop1_active", {3'b0, active}, 4'd1);
    chk_out("drop1", 4'b0100, 4'b0100);
    stepn(1);
    chk("drop2_active", {3'b0, active}, 4'd1);
    chk("drop2_strobe", {3'b0, pixel_strobe}, 4'd1);
    stepn(1);
    chk("drop3_active", {3'b0, active}, 4'd0);
    chk("drop3_strobe", {3'b0, pixel_strobe}, 4'd0);
    chk_out("drop3", 4'b0000, 4'b0000);
    stepn(4);
    chk("idle_active", {3'b0, active}, 4'd0);
    chk_out("idle", 4'b0000, 4'b0000);

    locked = 1'b1;
    stepn(502);
    chk("cnt500_active", {3'b0, active}, 4'd0);
    locked = 1'b0;
    stepn(3);
    locked = 1'b1;
    stepn(LC + 2);
    chk("requal_pre", {3'b0, active}, 4'd0);
    stepn(1);
    chk("requal_active", {3'b0, active}, 4'd1);
    chk("requal_strobe", {3'b0, pixel_strobe}, 4'd1);

    tb_blue  = 10'h000;
    tb_green = 10'h3FF;
    tb_red   = 10'h000;
    stepn(1);
    chk_out("r2p0", 4'b1010, 4'b1010);
    #1 reset = 1'b1;
    #1;
    chk("arst_active", {3'b0, active}, 4'd0);
    chk("arst_strobe", {3'b0, pixel_strobe}, 4'd0);
    chk_out("arst", 4'b0000, 4'b0000);
    stepn(1);
    chk_out("arst_hold", 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
